// File: rtl/shake_padder.sv
// SHAKE-128/256 message padder: packs 64-bit words into one rate block, applies 0x1F..0x80 padding.
// Latency: block valid the cycle after its last slot is written; the PAD phase zero-fills one slot per cycle.
// Backpressure: in_ready drops while padding or holding a block, until out_ack. SHAKE_PADDER_BLKCNT_EN adds blk_cnt.
module shake_padder (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic [63:0]   in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          is_last,
    input  logic [2:0]    byte_num,
    output logic [1343:0] out,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ack
`ifdef SHAKE_PADDER_BLKCNT_EN
    ,
    output logic [15:0]   blk_cnt
`endif
);

    typedef enum logic [1:0] {FILL, PAD, FULL} state_t;

    localparam logic [63:0] TOP_BIT = 64'h8000_0000_0000_0000;

    state_t      state;
    logic [4:0]  word_cnt;
    logic        mode_q;
    logic        msg_active;
    logic [63:0] blk_q [0:20];
    logic        mode_eff;
    logic [4:0]  rate_m1;
    logic [63:0] wr_word;

    function automatic logic [63:0] pad_word(input logic [63:0] d, input logic [2:0] n);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n))
                w[8*i +: 8] = d[8*i +: 8];
            else if (i == int'(n))
                w[8*i +: 8] = 8'h1F;
        end
        return w;
    endfunction

    // The rate is fixed by the mode seen on the first word of a message.
    assign mode_eff  = msg_active ? mode_q : mode;
    assign rate_m1   = mode_eff ? 5'd16 : 5'd20;
    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);

    always_comb begin
        wr_word = is_last ? pad_word(in, byte_num) : in;
        if (is_last && word_cnt == rate_m1)
            wr_word[63] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            word_cnt   <= '0;
            mode_q     <= 1'b0;
            msg_active <= 1'b0;
            out_last   <= 1'b0;
            for (int k = 0; k < 21; k++)
                blk_q[k] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        blk_q[word_cnt] <= wr_word;
                        if (!msg_active) begin
                            mode_q     <= mode;
                            msg_active <= 1'b1;
                        end
                        if (word_cnt == rate_m1) begin
                            state    <= FULL;
                            out_last <= is_last;
                        end else begin
                            word_cnt <= word_cnt + 5'd1;
                            if (is_last)
                                state <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (word_cnt == rate_m1) begin
                        blk_q[word_cnt] <= TOP_BIT;
                        state           <= FULL;
                        out_last        <= 1'b1;
                    end else begin
                        blk_q[word_cnt] <= '0;
                        word_cnt        <= word_cnt + 5'd1;
                    end
                end
                FULL: begin
                    if (out_ack) begin
                        for (int k = 0; k < 21; k++)
                            blk_q[k] <= '0;
                        word_cnt <= '0;
                        out_last <= 1'b0;
                        state    <= FILL;
                        if (out_last)
                            msg_active <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_comb begin
        out = '0;
        for (int k = 0; k < 21; k++) begin
            if (!(mode_q && k >= 17))
                out[64*k +: 64] = blk_q[k];
        end
    end

`ifdef SHAKE_PADDER_BLKCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blk_cnt <= '0;
        else if (state == FULL && out_ack) begin
            if (out_last)
                blk_cnt <= '0;
            else if (blk_cnt != 16'hFFFF)
                blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shake_padder.sv
// Directed bench for shake_padder: table of single-block messages plus hand sequences for stall, reset and mode latching.
module tb_shake_padder;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [63:0]   din;
    logic          in_valid;
    logic          in_ready;
    logic          is_last;
    logic [2:0]    byte_num;
    logic [1343:0] dout;
    logic          out_valid;
    logic          out_last;
    logic          out_ack;
`ifdef SHAKE_PADDER_BLKCNT_EN
    logic [15:0]   blk_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shake_padder dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .in       (din),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .is_last  (is_last),
        .byte_num (byte_num),
        .out      (dout),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ack  (out_ack)
`ifdef SHAKE_PADDER_BLKCNT_EN
        ,
        .blk_cnt  (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        mode;
        int          nw;
        logic [2:0]  n;
        logic [63:0] fill;
        logic [63:0] last_in;
        logic [63:0] exp_last_w;
        logic [63:0] exp_top;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [1343:0] exp);
        int bad;
        bad = -1;
        n_tests++;
        for (int k = 20; k >= 0; k--)
            if (dout[64*k +: 64] !== exp[64*k +: 64]) bad = k;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s word%0d: got %h want %h", name, bad, dout[64*bad +: 64], exp[64*bad +: 64]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] n);
        int t;
        din = d; is_last = last; byte_num = n; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t == 100) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        tick();
        in_valid = 1'b0; is_last = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    function automatic logic [1343:0] build_exp(input vec_t v);
        logic [1343:0] e;
        int top;
        e = '0;
        top = v.mode ? 16 : 20;
        for (int k = 0; k < v.nw - 1; k++) e[64*k +: 64] = v.fill;
        e[64*(v.nw-1) +: 64] = v.exp_last_w;
        e[64*top +: 64] = v.exp_top;
        return e;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        mode = v.mode;
        for (int k = 0; k < v.nw - 1; k++) send_word(v.fill, 1'b0, 3'd0);
        send_word(v.last_in, 1'b1, v.n);
        wait_valid(lat);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(v.exp_lat));
        chk_out({tag, "_out"}, build_exp(v));
        chk({tag, "_last"}, 64'(out_last), 64'd1);
        do_ack();
        chk({tag, "_ack_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ack_ready"}, 64'(in_ready), 64'd1);
        chk_out({tag, "_ack_clear"}, '0);
    endtask

    initial begin
        logic [1343:0] e;
        int lat;

        vecs[0] = '{1'b0, 1,  3'd0, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h000000000000001F, 64'h8000000000000000, 20};
        vecs[1] = '{1'b1, 2,  3'd3, 64'h1111111111111111, 64'h00000000AABBCCDD, 64'h000000001FBBCCDD, 64'h8000000000000000, 15};
        vecs[2] = '{1'b0, 21, 3'd7, 64'h0102030405060708, 64'h0011223344556677, 64'h9F11223344556677, 64'h9F11223344556677, 0};
        vecs[3] = '{1'b1, 17, 3'd0, 64'h2222222222222222, 64'h5555555555555555, 64'h800000000000001F, 64'h800000000000001F, 0};
        vecs[4] = '{1'b0, 5,  3'd7, 64'h3333333333333333, 64'hFFFFFFFFFFFFFFFF, 64'h1FFFFFFFFFFFFFFF, 64'h8000000000000000, 16};
        vecs[5] = '{1'b1, 3,  3'd1, 64'h4444444444444444, 64'h0123456789ABCDEF, 64'h0000000000001FEF, 64'h8000000000000000, 14};

        reset = 1'b1; mode = 1'b0; din = '0; in_valid = 1'b0; is_last = 1'b0;
        byte_num = '0; out_ack = 1'b0;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk_out("rst_out", '0);
        reset = 1'b0;
        tick();
        chk("rst_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Full non-final block, stall with a pending word and a mode flip, then a pure padding block.
        mode = 1'b1;
        e = '0;
        for (int k = 0; k < 17; k++) begin
            e[64*k +: 64] = {32'hC0DE0000, 32'(k)};
            send_word({32'hC0DE0000, 32'(k)}, 1'b0, 3'd0);
        end
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_last", 64'(out_last), 64'd0);
        chk("stall_ready", 64'(in_ready), 64'd0);
        din = 64'hBADBADBADBADBAD0; in_valid = 1'b1; mode = 1'b0;
        repeat (5) tick();
        chk_out("stall_out", e);
        chk("stall_valid_held", 64'(out_valid), 64'd1);
        do_ack();
        in_valid = 1'b0;
        chk("stall_ack_ready", 64'(in_ready), 64'd1);
        chk("stall_ack_valid", 64'(out_valid), 64'd0);
        do_ack();
        chk("stray_ack_ready", 64'(in_ready), 64'd1);
        send_word(64'hFFFF, 1'b1, 3'd0);
        wait_valid(lat);
        e = '0;
        e[63:0]       = 64'h000000000000001F;
        e[64*16 +: 64] = 64'h8000000000000000;
        chk("padblk_lat", 64'(lat), 64'd16);
        chk_out("padblk_out", e);
        chk("padblk_last", 64'(out_last), 64'd1);
        do_ack();

        // Reset in the middle of padding drops the block entirely.
        mode = 1'b0;
        for (int k = 0; k < 4; k++) send_word(64'hABCDABCDABCDABCD, 1'b0, 3'd0);
        send_word(64'hABCDABCDABCDABCD, 1'b1, 3'd2);
        repeat (3) tick();
        reset = 1'b1;
        #3;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk_out("midrst_out", '0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_ready", 64'(in_ready), 64'd1);
        run_vec(vecs[0], "postrst");

`ifdef SHAKE_PADDER_BLKCNT_EN
        mode = 1'b1;
        for (int w = 0; w < 40; w++) begin
            send_word(64'(w), w == 39, 3'd0);
            if (w == 16 || w == 33) begin
                chk("blk_valid", 64'(out_valid), 64'd1);
                do_ack();
                chk("blk_cnt", 64'(blk_cnt), (w == 16) ? 64'd1 : 64'd2);
            end
        end
        wait_valid(lat);
        chk("blk_final_last", 64'(out_last), 64'd1);
        do_ack();
        chk("blk_cnt_final", 64'(blk_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shake_padder.md
SHAKE_PADDER -- requirements
Module: shake_padder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port mode, input, 1; 0 = SHAKE-128 (rate 21 words / 1344 bits), 1 = SHAKE-256 (rate 17 words / 1088 bits).
REQ-004 SHALL have port in, input, 64, message word, little-endian bytes (byte 0 = in[7:0]).
REQ-005 SHALL have port in_valid, input, 1, word present on in.
REQ-006 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-007 SHALL have port is_last, input, 1, qualifies the final word of a message.
REQ-008 SHALL have port byte_num, input, 3, valid data bytes (0..7) in the final word; ignored when is_last=0.
REQ-009 SHALL have port out, output, 1344, rate block; word k at out[64k+63:64k]; words 17..20 forced to zero when mode=1.
REQ-010 SHALL have port out_valid, output, 1, rate block complete.
REQ-011 SHALL have port out_last, output, 1, the presented block carries the message padding.
REQ-012 SHALL have port out_ack, input, 1, permutation stage has absorbed the block.

Function
REQ-013 Word accepted when in_valid && in_ready; stored at slot word_cnt; word_cnt increments.
REQ-014 Non-final word stored unmodified; all 8 bytes are data.
REQ-015 Final word (is_last=1, byte_num=n): bytes 0..n-1 = in bytes, byte n = 0x1F, bytes n+1..7 = 0x00; n=0 yields 0x000000000000001F.
REQ-016 States: FILL (in_ready=1), PAD (in_ready=0), FULL (in_ready=0, out_valid=1).
REQ-017 FILL -> FULL when a non-final word fills slot RATE-1; out_last=0.
REQ-018 FILL -> PAD on final-word acceptance when slot < RATE-1; PAD writes 0x0 to one slot per cycle up to slot RATE-1, then -> FULL.
REQ-019 Slot RATE-1 of a padded block always has bit 63 set (0x80 ORed into byte 7), including when the final word lands there (e.g. n=7 gives byte 7 = 0x9F).
REQ-020 Final word accepted into slot RATE-1: direct FILL -> FULL, out_last=1, no PAD cycles.
REQ-021 out_valid rises the cycle after the slot-(RATE-1) write; out holds stable while out_valid=1.
REQ-022 FULL && out_ack: next cycle buffer cleared to zero, word_cnt=0, out_valid=0, out_last=0, state FILL; no word is accepted in the ack cycle.
REQ-023 out_ack outside FULL SHALL be ignored.
REQ-024 mode sampled when the first word of a message is accepted (word_cnt=0, no message in progress); changes mid-message ignored until the final block is acked.
REQ-025 A full last data word SHALL be sent with is_last=0, followed by a final word with byte_num=0; if this lands in slot 0, the block is a pure padding block (0x1F ... 0x80).
REQ-026 in_valid with in_ready=0 SHALL not alter state; producer holds the word.

Reset
REQ-027 On reset assertion, immediately: state FILL, word_cnt=0, buffer=0, out_valid=0, out_last=0, in_ready=1 one cycle after deassertion; mode latch = 0.
REQ-028 Reset mid-message or mid-PAD discards the partial block; no block is emitted.

Configuration
REQ-029 Macro SHAKE_PADDER_BLKCNT_EN defined: adds output blk_cnt [15:0], number of blocks acked in the current message, incremented on each out_ack in FULL, cleared on out_ack of an out_last block and on reset, saturating at 0xFFFF.
REQ-030 Macro undefined: no blk_cnt port or logic; all other behaviour identical.

Verification
REQ-031 mode=0, one word is_last=1 byte_num=0 -> 20 PAD cycles; out word0=0x000000000000001F, word20=0x8000000000000000, others 0, out_last=1.
REQ-032 mode=1, words 0x1111..11 then is_last byte_num=3 in=0x00000000AABBCCDD -> word1=0x000000001FBBCCDD, word16=0x8000000000000000, words 17..20=0.
REQ-033 mode=1, 17 non-final words -> out_valid, out_last=0, in_ready=0; stall 5 cycles with in_valid=1 -> out unchanged; out_ack -> in_ready=1 next cycle.
REQ-034 mode=0, final word in slot 20 byte_num=7 in=0x0011223344556677 -> word20=0x9F11223344556677, no PAD cycles, out_last=1.
REQ-035 Reset asserted during PAD after 5 words -> out_valid=0, buffer zero; next message output independent of discarded data.
REQ-036 With SHAKE_PADDER_BLKCNT_EN, mode=1, 40-word message -> blk_cnt 1, 2 after the first two acks, 0 after the third (out_last) ack.
